// File: rtl/ssd_pkg.sv
// Shared constants and the active-low hex-to-segment table for the
// Nexys4 eight-digit seven-segment scan controller.
package ssd_pkg;

    localparam int DIGITS = 8;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Cathodes a..g map to bits 0..6; a 0 lights the segment.
    function automatic logic [6:0] hexdec(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hexdec(nib);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Eight-digit seven-segment scan controller with a double-buffered display value.
// Optional build macro SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int PRESCALE = 100000,
    parameter int GUARD    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    input  logic [31:0] wr_data,
    input  logic [7:0]  wr_dp,
    output logic        wr_ready,
    input  logic [7:0]  dig_en,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST    = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
    localparam logic [2:0]    IDX_LAST = 3'(DIGITS - 1);

    logic [CW-1:0] count;
    logic [2:0]    idx;
    logic [31:0]   shadow_val, active_val;
    logic [7:0]    shadow_dp, active_dp;
    logic          pending;

    logic          tick, frame_end, xfer, show;
    logic [3:0]    nib;
    logic [6:0]    seg_dec;
    logic [7:0]    lz_blank;

    assign tick      = (count == LAST);
    assign frame_end = tick && (idx == IDX_LAST);

    // Handshake: a write transfers when wr_valid && wr_ready on a clock edge.
    // wr_ready is low while a captured value waits for the next frame boundary;
    // wr_valid during that time is dropped, not queued.
    assign wr_ready = ~pending;
    assign xfer     = wr_valid && !pending;

    assign nib = active_val[{idx, 2'b00} +: 4];

    ssd_hex_decode u_dec (
        .nib (nib),
        .seg (seg_dec)
    );

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // Digit i goes dark when it and every more significant nibble is zero
    // and its decimal point is off; digit 0 always shows.
    always_comb begin
        lz_blank = '0;
        for (int i = 1; i < DIGITS; i++) begin
            lz_blank[i] = ((active_val >> (4 * i)) == 32'd0) && !active_dp[i];
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign show = (count >= GUARD_C) && dig_en[idx] && !lz_blank[idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            active_val <= '0;
            active_dp  <= '0;
            pending    <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            count      <= tick ? '0 : count + CW'(1);
            if (tick) begin
                idx <= idx + 3'd1;
            end
            frame_tick <= frame_end;

            // A transfer landing on frame_end waits a full frame for its commit.
            if (xfer) begin
                shadow_val <= wr_data;
                shadow_dp  <= wr_dp;
                pending    <= 1'b1;
            end else if (frame_end && pending) begin
                active_val <= shadow_val;
                active_dp  <= shadow_dp;
                pending    <= 1'b0;
            end

            if (show) begin
                an  <= ~(8'h01 << idx);
                seg <= seg_dec;
                dp  <= ~active_dp[idx];
            end else begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: position-based display model, per-cycle output
// scoreboard and directed literal checks at PRESCALE=8, GUARD=2.
module tb_ssd_scan_ctrl;

    localparam int P     = 8;
    localparam int G     = 2;
    localparam int FRAME = 8 * P;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic [7:0]  wr_dp = '0;
    logic        wr_ready;
    logic [7:0]  dig_en = 8'hFF;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int tests = 0;
    int fails = 0;

    ssd_scan_ctrl #(.PRESCALE(P), .GUARD(G)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .wr_ready   (wr_ready),
        .dig_en     (dig_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          q;
    logic        m_pend;
    logic [31:0] m_sv, m_av;
    logic [7:0]  m_sd, m_ad;
    logic        m_xfer, m_fe, m_next_pend;
    logic [17:0] exp_q[$];

    // What the pins must show for scan position pos (cycles since reset).
    function automatic logic [16:0] expect_disp(input int pos, input logic [31:0] av,
                                                input logic [7:0] ad, input logic [7:0] en);
        int c, i;
        logic [3:0] nib;
        logic blank;
        logic [7:0] an_e;
        logic [6:0] seg_e;
        logic dp_e;
        c = pos % P;
        i = (pos / P) % 8;
        nib = 4'((av >> (4 * i)) & 32'hF);
        blank = (c < G) || !en[i];
`ifdef SSD_LEADING_ZERO_BLANK_EN
        if (i > 0 && (av >> (4 * i)) == 32'd0 && !ad[i]) blank = 1'b1;
`endif
        if (blank) begin
            an_e = 8'hFF; seg_e = 7'h7F; dp_e = 1'b1;
        end else begin
            an_e = ~(8'h01 << i); seg_e = hex_tab[nib]; dp_e = ~ad[i];
        end
        return {an_e, seg_e, dp_e, ((pos % FRAME) == FRAME - 1)};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            q      <= 0;
            m_pend <= 1'b0;
            m_sv   <= '0;
            m_sd   <= '0;
            m_av   <= '0;
            m_ad   <= '0;
            exp_q.push_back({8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1});
        end else begin
            m_xfer = wr_valid && !m_pend;
            m_fe   = ((q % FRAME) == FRAME - 1);
            m_next_pend = m_xfer ? 1'b1 : ((m_fe && m_pend) ? 1'b0 : m_pend);
            exp_q.push_back({expect_disp(q, m_av, m_ad, dig_en), !m_next_pend});
            if (m_xfer) begin
                m_sv <= wr_data;
                m_sd <= wr_dp;
            end else if (m_fe && m_pend) begin
                m_av <= m_sv;
                m_ad <= m_sd;
            end
            m_pend <= m_next_pend;
            q <= q + 1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [17:0] sb_exp, sb_act;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            sb_exp = exp_q.pop_front();
            sb_act = {an, seg, dp, frame_tick, wr_ready};
            tests++;
            if (sb_act !== sb_exp) begin
                fails++;
                $display("FAIL outputs @pos %0d: got an=%h seg=%h dp=%b ft=%b rdy=%b, expected an=%h seg=%h dp=%b ft=%b rdy=%b",
                         q - 1, sb_act[17:10], sb_act[9:3], sb_act[2], sb_act[1], sb_act[0],
                         sb_exp[17:10], sb_exp[9:3], sb_exp[2], sb_exp[1], sb_exp[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Return at the negedge where the outputs show scan position p.
    task automatic goto(input int p);
        int budget;
        budget = 0;
        while (q != p + 1 && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        if (q != p + 1) begin
            tests++;
            fails++;
            $display("FAIL goto: at position %0d, expected %0d", q - 1, p);
        end
    endtask

    task automatic write(input logic [31:0] d, input logic [7:0] p);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_dp    = p;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("reset_an", 32'(an), 32'hFF);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_dp", 32'(dp), 32'h1);
        chk("reset_ft", 32'(frame_tick), 32'h0);
        chk("reset_ready", 32'(wr_ready), 32'h1);
        reset = 1'b0;

        // blank scan of all zeros
        goto(1);   chk("guard_an", 32'(an), 32'hFF);
        goto(2);   chk("d0_an", 32'(an), 32'hFE);
                   chk("d0_seg_zero", 32'(seg), 32'h40);
        goto(63);  chk("ft_first", 32'(frame_tick), 32'h1);
`ifdef SSD_LEADING_ZERO_BLANK_EN
                   chk("d7_an_lz", 32'(an), 32'hFF);
`else
                   chk("d7_an", 32'(an), 32'h7F);
`endif
        goto(64);  chk("ft_low", 32'(frame_tick), 32'h0);
        goto(127); chk("ft_period", 32'(frame_tick), 32'h1);

        // mid-frame write, then an ignored second write
        goto(130); write(32'h89AB_CDEF, 8'h01);
                   chk("ready_drop", 32'(wr_ready), 32'h0);
        goto(150); write(32'h1111_1111, 8'hFF);
        goto(190); chk("ready_held", 32'(wr_ready), 32'h0);
        goto(191); chk("ready_back", 32'(wr_ready), 32'h1);
        goto(194); chk("new_d0_seg", 32'(seg), 32'h0E);
                   chk("new_d0_dp", 32'(dp), 32'h0);
        goto(202); chk("new_d1_seg", 32'(seg), 32'h06);
        goto(250); chk("new_d7_seg", 32'(seg), 32'h00);
                   chk("new_d7_an", 32'(an), 32'h7F);

        // write on frame_end, digit enables 1010_1010
        goto(254); write(32'h0000_0005, 8'h00);
                   chk("fe_write_ready", 32'(wr_ready), 32'h0);
                   dig_en = 8'b1010_1010;
        goto(258); chk("dis_d0_an", 32'(an), 32'hFF);
        goto(266); chk("en_d1_an", 32'(an), 32'hFD);
                   chk("en_d1_old", 32'(seg), 32'h06);
        goto(319); dig_en = 8'hFF;
        goto(322); chk("late_commit_seg", 32'(seg), 32'h12);

        // reset with a write pending
        goto(340); write(32'h7777_7777, 8'hFF);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_an", 32'(an), 32'hFF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_ready", 32'(wr_ready), 32'h1);
        reset = 1'b0;
        goto(2);   chk("post_rst_seg", 32'(seg), 32'h40);
        goto(130); chk("no_stale_seg", 32'(seg), 32'h40);

        // leading zeros
        goto(140); write(32'h0000_00A3, 8'h00);
        goto(194); chk("a3_d0_seg", 32'(seg), 32'h30);
        goto(202); chk("a3_d1_seg", 32'(seg), 32'h08);
                   chk("a3_d1_an", 32'(an), 32'hFD);
        goto(210);
`ifdef SSD_LEADING_ZERO_BLANK_EN
                   chk("a3_d2_dark", 32'(an), 32'hFF);
`else
                   chk("a3_d2_an", 32'(an), 32'hFB);
                   chk("a3_d2_seg", 32'(seg), 32'h40);
`endif
        goto(260); write(32'h0, 8'h00);
        goto(322); chk("zero_d0_an", 32'(an), 32'hFE);
                   chk("zero_d0_seg", 32'(seg), 32'h40);
        goto(330);
`ifdef SSD_LEADING_ZERO_BLANK_EN
                   chk("zero_d1_dark", 32'(an), 32'hFF);
`else
                   chk("zero_d1_an", 32'(an), 32'hFD);
`endif
        goto(384);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
